// File: rtl/dense_seq_24.sv
// rtl/dense_seq_24.sv - dense-layer sequencer/accumulator around inner_24 (optional ReLU: DENSE_SEQ_RELU_EN)
module dense_seq_24 #(
  parameter int N_LEN    = 16,
  parameter int IN_TILES = 4,
  parameter int OUT_DIM  = 24,
  localparam int XA_W = (IN_TILES > 1) ? $clog2(IN_TILES) : 1,
  localparam int WA_W = (OUT_DIM * IN_TILES > 1) ? $clog2(OUT_DIM * IN_TILES) : 1,
  localparam int YI_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [XA_W-1:0]          x_addr,
  input  logic [24*N_LEN-1:0]      x_data,
  output logic [WA_W-1:0]          w_addr,
  input  logic [24*N_LEN-1:0]      w_data,
  input  logic [OUT_DIM*N_LEN-1:0] b_vec,
  output logic                     run,
  output logic [24*N_LEN-1:0]      d1,
  output logic [24*N_LEN-1:0]      d2,
  input  logic [N_LEN-1:0]         q,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [N_LEN-1:0]         y_data,
  output logic [YI_W-1:0]          y_idx
);

  // Tag index 0 belongs to the element currently addressed; index DEPTH lines up with q.
  localparam int DEPTH = 5;
  localparam logic [XA_W-1:0] T_LAST = XA_W'(IN_TILES - 1);
  localparam logic [YI_W-1:0] R_LAST = YI_W'(OUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [XA_W-1:0]            xa_q, xa_d;
  logic [WA_W-1:0]            wa_q, wa_d;
  logic [YI_W-1:0]            r_q, r_d;
  logic [DEPTH:0]             tv_q, tv_d;
  logic [DEPTH:0][YI_W-1:0]   tr_q, tr_d;
  logic [DEPTH:0][XA_W-1:0]   tt_q, tt_d;
  logic [N_LEN-1:0]           acc_q, acc_d;
  logic                       yv_q, yv_d;
  logic [N_LEN-1:0]           yd_q, yd_d;
  logic [YI_W-1:0]            yi_q, yi_d;

  logic                       run_w;
  logic                       xfer_w;
  logic                       complete_w;
  logic [N_LEN-1:0]           bias_w;
  logic [N_LEN-1:0]           sum_w;
  logic [N_LEN-1:0]           y_val_w;

  // A held result stalls everything, including inner_24, so nothing in flight is lost.
  assign run_w      = busy_q & ~(yv_q & ~y_ready);
  assign xfer_w     = yv_q & y_ready;
  assign complete_w = run_w & tv_q[DEPTH] & (tt_q[DEPTH] == T_LAST);
  assign bias_w     = b_vec[int'(tr_q[DEPTH]) * N_LEN +: N_LEN];
  assign sum_w      = ((tt_q[DEPTH] == '0) ? bias_w : acc_q) + q;

`ifdef DENSE_SEQ_RELU_EN
  assign y_val_w = sum_w[N_LEN-1] ? '0 : sum_w;
`else
  assign y_val_w = sum_w;
`endif

  // Next-state: FSM, address/tag pipeline, accumulator and output register.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xa_d    = xa_q;
    wa_d    = wa_q;
    r_d     = r_q;
    tv_d    = tv_q;
    tr_d    = tr_q;
    tt_d    = tt_q;
    acc_d   = acc_q;
    yv_d    = yv_q;
    yd_d    = yd_q;
    yi_d    = yi_q;

    if (run_w) begin
      tv_d = {tv_q[DEPTH-1:0], 1'b0};
      tr_d = {tr_q[DEPTH-1:0], YI_W'(0)};
      tt_d = {tt_q[DEPTH-1:0], XA_W'(0)};
      if (tv_q[DEPTH]) begin
        acc_d = sum_w;
      end
    end

    if (complete_w) begin
      yv_d = 1'b1;
      yd_d = y_val_w;
      yi_d = tr_q[DEPTH];
    end else if (xfer_w) begin
      yv_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          busy_d   = 1'b1;
          xa_d     = '0;
          wa_d     = '0;
          r_d      = '0;
          tv_d[0]  = 1'b1;
          tr_d[0]  = '0;
          tt_d[0]  = '0;
        end
      end
      ISSUE: begin
        if (run_w) begin
          if (xa_q == T_LAST && r_q == R_LAST) begin
            state_d = DRAIN;
          end else begin
            if (xa_q == T_LAST) begin
              xa_d = '0;
              r_d  = r_q + 1'b1;
            end else begin
              xa_d = xa_q + 1'b1;
            end
            wa_d    = wa_q + 1'b1;
            tv_d[0] = 1'b1;
            tr_d[0] = r_d;
            tt_d[0] = xa_d;
          end
        end
      end
      DRAIN: begin
        if (xfer_w && yi_q == R_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any layer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xa_q    <= '0;
      wa_q    <= '0;
      r_q     <= '0;
      tv_q    <= '0;
      tr_q    <= '0;
      tt_q    <= '0;
      acc_q   <= '0;
      yv_q    <= 1'b0;
      yd_q    <= '0;
      yi_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xa_q    <= xa_d;
      wa_q    <= wa_d;
      r_q     <= r_d;
      tv_q    <= tv_d;
      tr_q    <= tr_d;
      tt_q    <= tt_d;
      acc_q   <= acc_d;
      yv_q    <= yv_d;
      yd_q    <= yd_d;
      yi_q    <= yi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_addr  = xa_q;
  assign w_addr  = wa_q;
  assign run     = run_w;
  assign d1      = x_data;
  assign d2      = w_data;
  assign y_valid = yv_q;
  assign y_data  = yd_q;
  assign y_idx   = yi_q;

endmodule

// File: tb/tb_dense_seq_24.sv
// tb/tb_dense_seq_24.sv - directed self-checking bench for dense_seq_24 with an inner_24 model
module tb_dense_seq_24;
  localparam int N = 16;
  localparam int F_LEN = 8;
  localparam int TILES = 4;
  localparam int ODIM = 24;

  logic            clk, rst, start, busy, done, run, y_valid, y_ready;
  logic [1:0]      x_addr;
  logic [6:0]      w_addr;
  logic [4:0]      y_idx;
  logic [24*N-1:0] x_data, w_data, d1, d2;
  logic [ODIM*N-1:0] b_vec;
  logic [N-1:0]    q, y_data;

  logic [24*N-1:0] x_mem [0:TILES-1];
  logic [24*N-1:0] w_mem [0:ODIM*TILES-1];
  logic [N-1:0]    p1, p2, p3;
  int              cyc;
  int              checks, failures;

  dense_seq_24 dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .b_vec(b_vec), .run(run), .d1(d1), .d2(d2), .q(q),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAMs, read-enabled by run so they freeze with the pipeline.
  always @(posedge clk) begin
    if (run) begin
      x_data <= x_mem[x_addr];
      w_data <= w_mem[w_addr];
    end
  end

  function automatic logic [N-1:0] dot24(input logic [24*N-1:0] a, input logic [24*N-1:0] b);
    logic signed [31:0] p;
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < 24; i++) begin
      p = $signed(a[i*N +: N]) * $signed(b[i*N +: N]);
      s = s + p[F_LEN +: N];
    end
    return s;
  endfunction

  // Four-stage inner_24 model, enabled by run.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0; p2 <= '0; p3 <= '0; q <= '0;
    end else if (run) begin
      p1 <= dot24(d1, d2);
      p2 <= p1;
      p3 <= p2;
      q  <= p3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [N-1:0] xv, input logic [N-1:0] wv, input logic [N-1:0] bstep);
    for (int t = 0; t < TILES; t++)
      for (int e = 0; e < 24; e++) x_mem[t][e*N +: N] = xv;
    for (int a = 0; a < ODIM*TILES; a++)
      for (int e = 0; e < 24; e++) w_mem[a][e*N +: N] = wv;
    for (int r = 0; r < ODIM; r++) b_vec[r*N +: N] = N'(r) * bstep;
  endtask

  task automatic run_layer(input logic [N-1:0] base, input logic [N-1:0] step,
                           input bit stall_en, input bit timing_en,
                           input int abort_row, input bit poke_start);
    int n, e0, last;
    bit stalled, aborted, held_ok, run_ok, done_seen;
    logic [N-1:0] hold_d;
    logic [4:0]   hold_i;
    n = 0; last = 0; stalled = 0; aborted = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    e0 = cyc;
    chk("busy_after_start", busy, 1);
    for (int budget = 0; budget < 1500 && n < ODIM && !aborted; budget++) begin
      start = (poke_start && budget == 10) ? 1'b1 : 1'b0;
      if (y_valid) begin
        if (abort_row >= 0 && int'(y_idx) == abort_row) begin
          rst = 1'b1;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_y_valid", y_valid, 0);
          chk("rst_y_data", y_data, 0);
          chk("rst_y_idx", y_idx, 0);
          chk("rst_run", run, 0);
          chk("rst_addr", {x_addr, w_addr}, 0);
          chk("rst_done", done, 0);
          aborted = 1;
        end else begin
          if (stall_en && !stalled && y_idx == 5'd2) begin
            y_ready = 1'b0;
            hold_d = y_data; hold_i = y_idx;
            held_ok = 1; run_ok = 1;
            for (int k = 0; k < 20; k++) begin
              @(negedge clk);
              if (y_data !== hold_d || y_idx !== hold_i || y_valid !== 1'b1) held_ok = 0;
              if (run !== 1'b0) run_ok = 0;
            end
            chk("stall_held", held_ok, 1);
            chk("stall_run_low", run_ok, 1);
            y_ready = 1'b1;
            stalled = 1;
          end
          chk("y_idx_order", y_idx, n);
          chk("y_data", y_data, base + N'(n) * step);
          if (timing_en) begin
            if (n == 0) chk("first_latency", cyc - e0, 9);
            else        chk("row_spacing", cyc - last, TILES);
          end
          last = cyc;
          n++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) done_seen = 1;
      end
      chk("abort_no_done", done_seen, 0);
    end else begin
      chk("row_count", n, ODIM);
      chk("done_pulse", done, 1);
      chk("busy_low_at_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    clk = 0; rst = 1; start = 0; y_ready = 1; cyc = 0;
    checks = 0; failures = 0;
    b_vec = '0; x_data = '0; w_data = '0;
    load(16'h0100, 16'h0100, 16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", y_valid, 0);
    chk("reset_run", run, 0);
    chk("reset_done", done, 0);
    rst = 0;
    @(negedge clk);

    // Unit inputs: 24 results of 0x6000 with exact timing.
    run_layer(16'h6000, 16'h0000, 0, 1, -1, 0);
    // Zero input, bias ramp.
    load(16'h0000, 16'h0100, 16'h0100);
    run_layer(16'h0000, 16'h0100, 0, 0, -1, 0);
    // Backpressure for 20 cycles on row 2.
    load(16'h0100, 16'h0100, 16'h0000);
    run_layer(16'h6000, 16'h0000, 1, 0, -1, 0);
    // Wrap-around to zero.
    load(16'h0800, 16'h0800, 16'h0000);
    run_layer(16'h0000, 16'h0000, 0, 0, -1, 0);
    // Negative result, clamped when ReLU is built in.
    load(16'h0100, 16'hFF00, 16'h0000);
`ifdef DENSE_SEQ_RELU_EN
    run_layer(16'h0000, 16'h0000, 0, 0, -1, 0);
`else
    run_layer(16'hA000, 16'h0000, 0, 0, -1, 0);
`endif
    // Reset during row 5, then a full restart with a stray start while busy.
    load(16'h0100, 16'h0100, 16'h0000);
    run_layer(16'h6000, 16'h0000, 0, 0, 5, 0);
    run_layer(16'h6000, 16'h0000, 0, 1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
